mem_req_initiator: RTL and testbench

- Initiator end of the single-cycle write / delayed-read memory protocol: write, read, addr, wdata, wr_valid out; rd_served, rdata back.
- Accepts host commands over a valid/ready interface and drives one protocol transaction at a time.
- Captures read data exactly Addr2ReadDelay cycles after the read strobe and returns it on a valid/ready response channel.
- Timing violations by the responder are flagged, both per response and in sticky error bits.

---
 rtl/mem_req_initiator.sv | 134 +++++++++++++
 tb/tb_mem_req_initiator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_initiator.sv
// Initiator for the single-cycle write / delayed-read memory protocol.
// Serialises host commands, times the read-data capture and flags responder timing faults.
module mem_req_initiator #(
    parameter int AW             = 1,
    parameter int DW             = 1,
    parameter int Addr2ReadDelay = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          write,
    output logic          wr_valid,
    output logic          read,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    input  logic          rd_served,
    input  logic [DW-1:0] rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          err_late,
    output logic          err_spurious
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        RSP  = 3'd4
    } state_t;

    // Counter preload when entering WAIT; the RD cycle itself already accounts for one delay cycle.
    localparam logic [3:0] WAIT_INIT = (Addr2ReadDelay > 0) ? 4'(Addr2ReadDelay - 1) : 4'd0;

    state_t     state;
    logic [3:0] cnt;
    logic       sample_cycle;

    assign cmd_ready = (state == IDLE);

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        sample_cycle = 1'b0;
        if (state == RD && Addr2ReadDelay == 0)
            sample_cycle = 1'b1;
        if (state == WAIT && cnt == 4'd0)
            sample_cycle = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so later statements
    // in this block see the pre-edge values and a later assignment wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            write        <= 1'b0;
            wr_valid     <= 1'b0;
            read         <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            err_late     <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (rd_served && !sample_cycle)
                err_spurious <= 1'b1;

            // Capture is shared by RD (zero delay) and the last WAIT cycle.
            if (sample_cycle) begin
                state     <= RSP;
                rsp_valid <= 1'b1;
                rsp_err   <= !rd_served;
                rsp_data  <= rd_served ? rdata : '0;
                if (!rd_served)
                    err_late <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr <= cmd_addr;
                        if (cmd_write) begin
                            wdata    <= cmd_wdata;
                            write    <= 1'b1;
                            wr_valid <= 1'b1;
                            state    <= WR;
                        end else begin
                            read  <= 1'b1;
                            state <= RD;
                        end
                    end
                end
                WR: begin
                    write    <= 1'b0;
                    wr_valid <= 1'b0;
                    state    <= IDLE;
                end
                RD: begin
                    read <= 1'b0;
                    if (!sample_cycle) begin
                        cnt   <= WAIT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    write     <= 1'b0;
                    wr_valid  <= 1'b0;
                    read      <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed bench: one zero-delay instance (default widths) and one Addr2ReadDelay=3, DW=8 instance.
module tb_mem_req_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance with default parameters.
    logic c0_cmd_valid = 0, c0_cmd_ready, c0_cmd_write = 0;
    logic [0:0] c0_cmd_addr = '0, c0_cmd_wdata = '0;
    logic c0_write, c0_wr_valid, c0_read;
    logic [0:0] c0_addr, c0_wdata, c0_rdata = '0, c0_rsp_data;
    logic c0_rd_served = 0, c0_rsp_valid, c0_rsp_ready = 0, c0_rsp_err, c0_err_late, c0_err_spurious;

    mem_req_initiator dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(c0_cmd_valid), .cmd_ready(c0_cmd_ready), .cmd_write(c0_cmd_write),
        .cmd_addr(c0_cmd_addr), .cmd_wdata(c0_cmd_wdata),
        .write(c0_write), .wr_valid(c0_wr_valid), .read(c0_read),
        .addr(c0_addr), .wdata(c0_wdata),
        .rd_served(c0_rd_served), .rdata(c0_rdata),
        .rsp_valid(c0_rsp_valid), .rsp_ready(c0_rsp_ready), .rsp_data(c0_rsp_data),
        .rsp_err(c0_rsp_err), .err_late(c0_err_late), .err_spurious(c0_err_spurious)
    );

    // Instance with a three-cycle read delay and byte data.
    logic c3_cmd_valid = 0, c3_cmd_ready, c3_cmd_write = 0;
    logic [3:0] c3_cmd_addr = '0, c3_addr;
    logic [7:0] c3_cmd_wdata = '0, c3_wdata, c3_rdata, c3_rsp_data;
    logic c3_write, c3_wr_valid, c3_read, c3_rd_served;
    logic c3_rsp_valid, c3_rsp_ready = 0, c3_rsp_err, c3_err_late, c3_err_spurious;

    // Responder side is driven either by hand or by the automatic responder below.
    logic       man_srv = 0, auto_srv = 0;
    logic [7:0] man_data = '0, auto_data = '0;
    assign c3_rd_served = man_srv | auto_srv;
    assign c3_rdata     = auto_srv ? auto_data : man_data;

    mem_req_initiator #(.AW(4), .DW(8), .Addr2ReadDelay(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(c3_cmd_valid), .cmd_ready(c3_cmd_ready), .cmd_write(c3_cmd_write),
        .cmd_addr(c3_cmd_addr), .cmd_wdata(c3_cmd_wdata),
        .write(c3_write), .wr_valid(c3_wr_valid), .read(c3_read),
        .addr(c3_addr), .wdata(c3_wdata),
        .rd_served(c3_rd_served), .rdata(c3_rdata),
        .rsp_valid(c3_rsp_valid), .rsp_ready(c3_rsp_ready), .rsp_data(c3_rsp_data),
        .rsp_err(c3_rsp_err), .err_late(c3_err_late), .err_spurious(c3_err_spurious)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Automatic responder and stream monitor.
    logic       stream_en = 0;
    int         overlaps = 0, n_writes = 0, n_rsp = 0;
    logic [7:0] rsp_log [4];

    initial begin
        forever begin
            tick();
            if (stream_en && c3_read) begin
                auto_data = 8'hC0 | {4'h0, c3_addr};
                repeat (3) tick();
                auto_srv = 1'b1;
                tick();
                auto_srv = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            tick();
            if (stream_en) begin
                if (c3_write && c3_read) overlaps++;
                if (c3_write) n_writes++;
                if (c3_rsp_valid && c3_rsp_ready) begin
                    if (n_rsp < 4) rsp_log[n_rsp] = c3_rsp_data;
                    n_rsp++;
                end
            end
        end
    end

    // Present one command to dut3 and hold it until accepted.
    task automatic send3(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int waited = 0;
        c3_cmd_valid = 1'b1;
        c3_cmd_write = wr;
        c3_cmd_addr  = a;
        c3_cmd_wdata = d;
        while (!c3_cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (waited >= 50) check("send3_timeout", 32'(waited), 32'd0);
        tick();
        c3_cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_write", c0_write, 0);
        check("rst_read", c0_read, 0);
        check("rst_addr", c0_addr, 0);
        check("rst_rsp_valid", c0_rsp_valid, 0);
        check("rst_cmd_ready", c0_cmd_ready, 1);
        check("rst_err3", {c3_err_late, c3_err_spurious, c3_rsp_valid}, 0);

        // Zero-delay instance: single write
        c0_cmd_valid = 1; c0_cmd_write = 1; c0_cmd_addr = 1; c0_cmd_wdata = 1;
        tick();
        c0_cmd_valid = 0;
        check("wr_strobe", {c0_write, c0_wr_valid, c0_read}, 3'b110);
        check("wr_addr_data", {c0_addr, c0_wdata}, 2'b11);
        check("wr_cmd_ready", c0_cmd_ready, 0);
        tick();
        check("wr_done", {c0_write, c0_wr_valid, c0_cmd_ready, c0_rsp_valid}, 4'b0010);
        check("wr_addr_hold", c0_addr, 1);

        // Zero-delay instance: read served in the strobe cycle
        c0_cmd_valid = 1; c0_cmd_write = 0; c0_cmd_addr = 1;
        tick();
        c0_cmd_valid = 0;
        check("rd0_strobe", {c0_read, c0_write, c0_addr}, 3'b101);
        c0_rd_served = 1; c0_rdata = 1;
        tick();
        c0_rd_served = 0; c0_rdata = 0;
        check("rd0_rsp", {c0_rsp_valid, c0_rsp_data, c0_rsp_err, c0_read}, 4'b1100);
        c0_rsp_ready = 1;
        tick();
        c0_rsp_ready = 0;
        check("rd0_idle", {c0_rsp_valid, c0_cmd_ready}, 2'b01);
        check("rd0_errs", {c0_err_late, c0_err_spurious}, 0);

        // Delay-3 instance: on-time answer, response stalled four cycles
        c3_cmd_valid = 1; c3_cmd_write = 0; c3_cmd_addr = 4'h5;
        tick();
        c3_cmd_valid = 0;
        check("rd3_strobe", {c3_read, c3_addr}, 5'b1_0101);
        repeat (2) tick();
        check("rd3_wait", {c3_read, c3_rsp_valid, c3_cmd_ready}, 0);
        tick();
        man_srv = 1; man_data = 8'hA5;
        check("rd3_sample_cycle", {c3_rsp_valid, c3_cmd_ready}, 0);
        tick();
        man_srv = 0; man_data = 0;
        check("rd3_rsp", {c3_rsp_valid, c3_rsp_err, c3_rsp_data}, {2'b10, 8'hA5});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd3_stall", {c3_rsp_valid, c3_cmd_ready, c3_rsp_data}, {2'b10, 8'hA5});
        end
        c3_rsp_ready = 1;
        tick();
        c3_rsp_ready = 0;
        check("rd3_release", {c3_rsp_valid, c3_cmd_ready}, 2'b01);
        check("rd3_errs", {c3_err_late, c3_err_spurious}, 0);

        // Delay-3 instance: answer one cycle late
        c3_cmd_valid = 1; c3_cmd_write = 0; c3_cmd_addr = 4'h6;
        tick();
        c3_cmd_valid = 0;
        repeat (4) tick();
        man_srv = 1; man_data = 8'h3C;
        check("late_rsp", {c3_rsp_valid, c3_rsp_err, c3_rsp_data}, {2'b11, 8'h00});
        check("late_flags", {c3_err_late, c3_err_spurious}, 2'b10);
        tick();
        man_srv = 0; man_data = 0;
        check("late_spurious", {c3_err_late, c3_err_spurious}, 2'b11);
        c3_rsp_ready = 1;
        tick();
        c3_rsp_ready = 0;
        repeat (3) tick();
        check("late_sticky", {c3_err_late, c3_err_spurious, c3_cmd_ready}, 3'b111);

        // Delay-3 instance: reset while WAIT counter is 1
        c3_cmd_valid = 1; c3_cmd_write = 0; c3_cmd_addr = 4'h9;
        tick();
        c3_cmd_valid = 0;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_outs", {c3_write, c3_wr_valid, c3_read, c3_addr, c3_wdata, c3_rsp_valid,
                               c3_rsp_data, c3_rsp_err, c3_err_late, c3_err_spurious}, 0);
        check("mid_rst_ready", c3_cmd_ready, 1);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (c3_rsp_valid) seen++;
            end
            check("mid_rst_no_rsp", 32'(seen), 0);
        end

        // Delay-3 instance: back-to-back stream with automatic responder
        c3_rsp_ready = 1;
        stream_en = 1;
        send3(1'b1, 4'h1, 8'h11);
        send3(1'b0, 4'h2, 8'h00);
        send3(1'b1, 4'h3, 8'h33);
        send3(1'b0, 4'h4, 8'h00);
        repeat (12) tick();
        stream_en = 0;
        check("stream_overlap", 32'(overlaps), 0);
        check("stream_writes", 32'(n_writes), 2);
        check("stream_nrsp", 32'(n_rsp), 2);
        check("stream_rsp0", rsp_log[0], 8'hC2);
        check("stream_rsp1", rsp_log[1], 8'hC4);
        check("stream_errs", {c3_err_late, c3_err_spurious}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
